// File: rtl/ahb_ap_master.sv
`default_nettype none
// ahb_ap_master: single-transfer AHB-Lite master behind the access point. Rev 1.0
// Optional build macro AHB_MASTER_TIMEOUT_EN aborts a transfer stuck on HREADY low.
module ahb_ap_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ren,
  input  logic        wen,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_ERR2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_lat, wdata_lat;
  logic [2:0]  size_lat;
  logic        byte_lat, write_lat;
  logic        accept, set_err, capture, timeout_hit;
  logic [7:0]  rd_lane;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] low_cnt;
  logic             bus_phase;

  assign bus_phase   = (state == S_ADDR) || (state == S_DATA) || (state == S_ERR2);
  // Fires on the cycle that would be the TIMEOUT_CYCLES-th consecutive low cycle.
  assign timeout_hit = bus_phase && !HREADY && (low_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST || !bus_phase || HREADY) low_cnt <= '0;
    else                             low_cnt <= low_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    set_err   = 1'b0;
    capture   = 1'b0;
    HTRANS    = 2'b00;
    case (state)
      S_IDLE: begin
        if (ren || wen) begin
          accept = 1'b1;
          // Misaligned word accesses never reach the bus.
          if (!byte_en && (addr[1:0] != 2'b00)) begin
            state_nxt = S_DONE;
            set_err   = 1'b1;
          end else begin
            state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        HTRANS = 2'b10;
        if (HREADY) state_nxt = S_DATA;
        else if (timeout_hit) begin
          state_nxt = S_DONE;
          set_err   = 1'b1;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          state_nxt = S_DONE;
          if (HRESP) set_err = 1'b1;
          else       capture = !write_lat;
        end else if (HRESP) begin
          state_nxt = S_ERR2;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
          set_err   = 1'b1;
        end
      end
      S_ERR2: begin
        if (HREADY || timeout_hit) begin
          state_nxt = S_DONE;
          set_err   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_lane = HRDATA[7:0];
    case (addr_lat[1:0])
      2'd1:    rd_lane = HRDATA[15:8];
      2'd2:    rd_lane = HRDATA[23:16];
      2'd3:    rd_lane = HRDATA[31:24];
      default: rd_lane = HRDATA[7:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_lat  <= '0;
      wdata_lat <= '0;
      size_lat  <= '0;
      byte_lat  <= 1'b0;
      write_lat <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        addr_lat  <= addr;
        wdata_lat <= wdata;
        byte_lat  <= byte_en;
        write_lat <= wen;
        size_lat  <= byte_en ? 3'b000 : 3'b010;
      end
      // err is sticky until the next command is accepted.
      if (accept)       err <= set_err;
      else if (set_err) err <= 1'b1;
      if (capture) rdata <= byte_lat ? {24'h0, rd_lane} : HRDATA;
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign HADDR     = addr_lat;
  assign HWRITE    = write_lat;
  assign HSIZE     = size_lat;
  assign HWDATA    = byte_lat ? {4{wdata_lat[7:0]}} : wdata_lat;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_ap_master.sv
`default_nettype none
// tb_ahb_ap_master: directed transactions checked cycle by cycle against a transaction-level model.
module tb_ahb_ap_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ren, wen, byte_en;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 CLK = ~CLK;

  ahb_ap_master #(.TIMEOUT_CYCLES(4), .HPROT_VAL(4'b0011)) dut (
    .CLK(CLK), .RST(RST), .ren(ren), .wen(wen), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  int checks = 0;
  int errors = 0;

  logic        active = 1'b0;
  int          cur_k, done_at;
  logic        e_busy, e_done, e_err, e_addr_phase, e_data_phase, e_hwrite;
  logic [1:0]  e_trans;
  logic [2:0]  e_hsize;
  logic [31:0] e_rdata, e_haddr, e_hwdata;
  logic [31:0] m_rdata;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (active) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("htrans", 32'(HTRANS), 32'(e_trans));
      chk("err", 32'(err), 32'(e_err));
      chk("rdata", rdata, e_rdata);
      chk("hburst", 32'(HBURST), 32'h0);
      chk("hprot", 32'(HPROT), 32'h3);
      chk("hmastlock", 32'(HMASTLOCK), 32'h0);
      if (e_addr_phase) begin
        chk("haddr", HADDR, e_haddr);
        chk("hwrite", 32'(HWRITE), 32'(e_hwrite));
        chk("hsize", 32'(HSIZE), 32'(e_hsize));
      end
      if (e_data_phase) chk("hwdata", HWDATA, e_hwdata);
      if (done) done_at = cur_k;
    end
  end

  // One command; cycle k=0 presents it, the edge ending k=0 accepts it.
  // aw/dw: wait cycles in address/data phase; rerr: two-cycle ERROR response.
  task automatic run(input bit wr, input bit byt, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] hr, input int aw, input int dw, input bit rerr,
                     input bit both, input bit hold, input int lit_done);
    bit          unal, req;
    int          d0, dc;
    logic [31:0] new_rdata;
    unal = !byt && (a[1:0] != 2'b00);
    d0   = 2 + aw;
    if (unal)      dc = 1;
    else if (rerr) dc = d0 + dw + 2;
    else           dc = d0 + dw + 1;
    new_rdata = m_rdata;
    if (!wr && !rerr && !unal) new_rdata = byt ? {24'h0, hr[8*a[1:0] +: 8]} : hr;
    done_at = -1;
    for (int k = 0; k <= dc + 1; k++) begin
      @(posedge CLK); #1;
      req     = (k == 0) || (hold && k <= dc);
      ren     = req && (!wr || both);
      wen     = req && wr;
      byte_en = byt; addr = a; wdata = wd; HRDATA = hr;
      HREADY  = 1'b1; HRESP = 1'b0;
      if (!unal) begin
        if (k >= 1 && k < 1 + aw)            HREADY = 1'b0;
        else if (k >= d0 && k < d0 + dw)     HREADY = 1'b0;
        else if (rerr && k == d0 + dw)       begin HREADY = 1'b0; HRESP = 1'b1; end
        else if (rerr && k == d0 + dw + 1)   HRESP = 1'b1;
      end
      cur_k        = k;
      e_busy       = (k >= 1) && (k <= dc);
      e_done       = (k == dc);
      e_trans      = (!unal && k >= 1 && k < d0) ? 2'b10 : 2'b00;
      e_addr_phase = (e_trans == 2'b10);
      e_data_phase = wr && !unal && (k >= d0) && (k < dc);
      e_haddr      = a;
      e_hwrite     = wr;
      e_hsize      = byt ? 3'b000 : 3'b010;
      e_hwdata     = byt ? {4{wd[7:0]}} : wd;
      e_err        = (k == 0) ? m_err : ((k >= dc) ? (unal || rerr) : 1'b0);
      e_rdata      = (k >= dc) ? new_rdata : m_rdata;
      active       = 1'b1;
    end
    @(negedge CLK); #1;
    active  = 1'b0;
    ren     = 1'b0; wen = 1'b0;
    m_rdata = new_rdata;
    m_err   = unal || rerr;
    chk("done_cycle", 32'(done_at), 32'(lit_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    ren = 0; wen = 0; byte_en = 0; addr = 0; wdata = 0;
    HRDATA = 0; HREADY = 1; HRESP = 0; RST = 1;
    m_rdata = 0; m_err = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(posedge CLK); #1; RST = 0;

    //  wr byt addr          wdata         hrdata        aw dw rerr both hold done
    run(1, 0, 32'h2000_0010, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 0, 0, 3);
    run(0, 1, 32'h2000_0003, 32'h0,         32'h1122_3344, 0, 0, 0, 0, 0, 3);
    chk("byte_rd_lane3", rdata, 32'h0000_0011);
    run(0, 0, 32'h2000_0020, 32'h0,         32'hCAFE_F00D, 0, 2, 0, 0, 0, 5);
    chk("word_rd_wait", rdata, 32'hCAFE_F00D);
    run(1, 0, 32'h2000_0030, 32'h0102_0304, 32'h0,        0, 0, 1, 0, 0, 4);
    chk("err_resp_err", 32'(err), 32'h1);
    chk("err_resp_rdata", rdata, 32'hCAFE_F00D);
    run(0, 0, 32'h2000_0040, 32'h0,         32'h1234_5678, 1, 0, 0, 0, 0, 4);
    chk("rd_after_err", rdata, 32'h1234_5678);
    chk("rd_after_err_e", 32'(err), 32'h0);
    run(0, 0, 32'h2000_0002, 32'h0,         32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1);
    chk("unal_rdata", rdata, 32'h1234_5678);
    chk("unal_err", 32'(err), 32'h1);
    run(1, 1, 32'h2000_0001, 32'h0000_00A5, 32'h0,        0, 0, 0, 0, 1, 3);
    run(1, 0, 32'h2000_0050, 32'h0BAD_F00D, 32'h0,        0, 1, 0, 1, 0, 4);
    run(0, 1, 32'h2000_0001, 32'h0,         32'h1122_3344, 0, 0, 0, 0, 0, 3);
    chk("byte_rd_lane1", rdata, 32'h0000_0033);
    run(0, 1, 32'h2000_0002, 32'h0,         32'hA1B2_C3D4, 2, 1, 0, 0, 0, 6);
    chk("byte_rd_lane2", rdata, 32'h0000_00B2);

`ifdef AHB_MASTER_TIMEOUT_EN
    @(posedge CLK); #1;
    ren = 1; byte_en = 0; addr = 32'h2000_0200; HREADY = 1; HRESP = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK); #1;
      ren = 0; HREADY = 0;
      @(negedge CLK);
      chk("to_done", 32'(done), 32'(k == 5));
      chk("to_busy", 32'(busy), 32'h1);
      chk("to_rdata", rdata, m_rdata);
      if (k == 5) chk("to_err", 32'(err), 32'h1);
      if (k == 5) chk("to_htrans", 32'(HTRANS), 32'h0);
    end
    @(posedge CLK); #1; HREADY = 1;
    @(negedge CLK);
    chk("to_idle", 32'(busy), 32'h0);
    m_err = 1;
`endif

    // Reset while the data phase is stretched by a wait state.
    @(posedge CLK); #1;
    ren = 1; byte_en = 0; addr = 32'h2000_0100; HREADY = 1; HRESP = 0; HRDATA = 32'h55AA_55AA;
    @(posedge CLK); #1; ren = 0;
    @(posedge CLK); #1; HREADY = 0; RST = 1;
    @(negedge CLK);
    chk("rstmid_pre_busy", 32'(busy), 32'h1);
    @(posedge CLK); #1; RST = 0; HREADY = 1;
    @(negedge CLK);
    chk("rstmid_htrans", 32'(HTRANS), 32'h0);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    @(negedge CLK);
    chk("rstmid_done2", 32'(done), 32'h0);
    chk("rstmid_rdata", rdata, 32'h0);
    m_rdata = 0; m_err = 0;

    run(0, 0, 32'h2000_0104, 32'h0,         32'h0F0E_0D0C, 0, 0, 0, 0, 0, 3);
    chk("rd_after_rst", rdata, 32'h0F0E_0D0C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
